// File: rtl/cmp_window_tracker_pkg.sv
// rtl/cmp_window_tracker_pkg.sv - shared types and helpers for the window statistics tracker
package cmp_window_tracker_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  // One-hot magnitude relation of a versus b
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_t;

  localparam cmp_t CMP_EQ = 3'b100;
  localparam cmp_t CMP_LT = 3'b010;
  localparam cmp_t CMP_GT = 3'b001;

  // Frame result laid out at the default build widths
  typedef struct packed {
    logic [DEF_WIDTH-1:0] max;
    logic [DEF_WIDTH-1:0] min;
    logic [DEF_CNT_W-1:0] cnt;
    logic [DEF_CNT_W-1:0] rise;
    logic [DEF_CNT_W-1:0] fall;
    logic [DEF_CNT_W-1:0] rep;
  } result_t;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/cmp_window_tracker_if.sv
// rtl/cmp_window_tracker_if.sv - sample input and frame result handshakes
interface cmp_window_tracker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_rise;
  logic [CNT_W-1:0] out_fall;
  logic [CNT_W-1:0] out_rep;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_cnt, out_rise, out_fall, out_rep
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_cnt, out_rise, out_fall, out_rep
  );
endinterface

// File: rtl/cmp_window_tracker_mag_cmp.sv
// rtl/cmp_window_tracker_mag_cmp.sv - unsigned magnitude compare, one-hot eq/lt/gt
module mag_cmp
  import cmp_window_tracker_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_t             rel
);

  always_comb begin
    rel.eq = (a == b);
    rel.lt = (a <  b);
    rel.gt = (a >  b);
  end

endmodule

// File: rtl/cmp_window_tracker.sv
// rtl/cmp_window_tracker.sv - per-frame max/min/count/rise/fall/repeat statistics
module cmp_window_tracker
  import cmp_window_tracker_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  cmp_window_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  state_t           state_q, state_d;
  logic             in_ready_c, out_valid_c, accept;
  logic [WIDTH-1:0] max_q, min_q, prev_q;
  logic [CNT_W-1:0] cnt_q, rise_q, fall_q, rep_q;
  cmp_t             cmp_max, cmp_min, cmp_prev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign accept = bus.in_valid && in_ready_c;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max  (.a(bus.in_data), .b(max_q),  .rel(cmp_max));
  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min  (.a(bus.in_data), .b(min_q),  .rel(cmp_min));
  mag_cmp #(.WIDTH(WIDTH)) u_cmp_prev (.a(bus.in_data), .b(prev_q), .rel(cmp_prev));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.in_last ? DONE : ACC;
      ACC:     if (accept && bus.in_last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decode the state register only
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE:    in_ready_c  = 1'b1;
      ACC:     in_ready_c  = 1'b1;
      DONE:    out_valid_c = 1'b1;
      default: in_ready_c  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q  <= '0;
      min_q  <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      rep_q  <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        max_q  <= bus.in_data;
        min_q  <= bus.in_data;
        prev_q <= bus.in_data;
        cnt_q  <= CNT_W'(1);
        rise_q <= '0;
        fall_q <= '0;
        rep_q  <= '0;
      end else begin
        if (cmp_max == CMP_GT) max_q <= bus.in_data;
        if (cmp_min == CMP_LT) min_q <= bus.in_data;
        case (cmp_prev)
          CMP_GT:  rise_q <= sat_inc(rise_q);
          CMP_LT:  fall_q <= sat_inc(fall_q);
          CMP_EQ:  rep_q  <= sat_inc(rep_q);
          default: rep_q  <= rep_q;
        endcase
        cnt_q  <= sat_inc(cnt_q);
        prev_q <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_max   = max_q;
  assign bus.out_min   = min_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_rise  = rise_q;
  assign bus.out_fall  = fall_q;
  assign bus.out_rep   = rep_q;

endmodule

// File: doc/cmp_window_tracker.md
# cmp_window_tracker

- Streaming statistics stage that consumes a frame of WIDTH-bit samples over a valid/ready handshake.
- Per frame it reports running max, running min, sample count, and how many samples rose above, fell below or repeated the previous sample.
- It sits downstream of the sample source and is built around the team's magnitude-compare function (eq/lt/gt).
- Results are presented on a registered output handshake once per frame.

## Interface
- WIDTH, 4, sample width in bits
- CNT_W, 8, width of every counter output
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  sample present
- in_ready  output  1  block can accept a sample
- in_data  input  WIDTH  sample, unsigned
- in_last  input  1  qualifies final sample of frame
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes result
- out_max  output  WIDTH  largest sample in frame
- out_min  output  WIDTH  smallest sample in frame
- out_cnt  output  CNT_W  samples in frame, saturating
- out_rise  output  CNT_W  samples strictly greater than predecessor, saturating
- out_fall  output  CNT_W  samples strictly less than predecessor, saturating
- out_rep  output  CNT_W  samples equal to predecessor, saturating

## Operation
- One clock; reset is asynchronous and active-high.
- Accept = in_valid && in_ready, sampled on a rising clk edge with rst low.
- FSM states:
  - IDLE, the reset state: in_ready=1, out_valid=0.
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE transitions:
  - Accept loads max=min=prev=in_data, cnt=1, rise=fall=rep=0.
  - Go to DONE if in_last=1, else go to ACC.
- ACC, on each accept:
  - Compare in_data against max, min and prev as unsigned values.
  - If gt vs max, max<=in_data. If lt vs min, min<=in_data.
  - Exactly one of rise/fall/rep increments, by in_data gt/lt/eq prev.
  - cnt increments; prev<=in_data.
  - Go to DONE if in_last=1.
- DONE: out_* are driven directly from the accumulators. When out_valid && out_ready, go to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap. The invariant rise+fall+rep = cnt-1 holds only while nothing has saturated.
- in_data, in_last: don't-care when no accept occurs. No state changes without an accept, including the ACC bubble cycles.
- out_* hold their values after the handshake, until the next frame's first accept overwrites them.
- Backpressure: in_ready is low in DONE. A sample offered in DONE is not accepted and must be held by the source.
- Reset, any time (including mid-frame or in DONE):
  - FSM goes to IDLE immediately.
  - All accumulators clear to 0 and out_valid goes to 0.
  - The partial frame is discarded with no result emitted.

## Timing
- Reset values: out_valid=0, out_max=0, out_min=0, out_cnt=0, out_rise=0, out_fall=0, out_rep=0. in_ready=1 (IDLE decode), but no accept occurs while rst is high.
- in_ready and out_valid are pure decodes of the state register: no combinational path from any input.
- Throughput: one sample per cycle in IDLE/ACC.
- Latency:
  - out_valid rises on the clock edge that accepts the in_last sample, and is visible the same cycle the FSM enters DONE.
  - In the next cycle, at the earliest, it completes with out_ready=1.
- Minimum frame gap is 1 cycle (the DONE cycle). A one-sample frame therefore cycles IDLE→DONE→IDLE.
- out_ready=1 outside DONE has no effect.

## Structure
- The shared package holds:
  - the state enum {IDLE, ACC, DONE};
  - a packed result struct: max, min, cnt, rise, fall, rep;
  - the CNT_W saturation-max constant function.
- Sub-module mag_cmp, parameterized by WIDTH:
  - purely combinational, outputs eq/lt/gt for a vs b, exactly one high;
  - instantiated three times: vs max, vs min, vs prev.
- Top level holds the FSM, the accumulators and the saturating-increment logic.

## Test plan
- Frame 3,7,7,2,9(last), out_ready=1 → out_max=9, out_min=2, out_cnt=5, out_rise=2, out_fall=1, out_rep=1, out_valid for exactly 1 cycle.
- Single-sample frame 0xA with in_last → next cycle out_max=out_min=0xA, cnt=1, rise=fall=rep=0; FSM then back to IDLE.
- out_ready held low 5 cycles in DONE, in_valid=1 → in_ready=0 throughout, outputs stable, no sample consumed; the held sample is accepted on the cycle after the handshake.
- CNT_W=4, frame of 20 strictly increasing-mod samples 0,1,...,15,0,1,2,3 → out_cnt=15 saturated, out_rise=15 saturated, out_fall=1.
- rst pulsed asynchronously (between edges) after 3 samples of a frame → all outputs 0 immediately. A following frame 5,5(last) gives cnt=2, rep=1, max=min=5 with no residue.
- Random valid gaps in a frame 0xF,0x0,0xF(last) → identical to the gapless result: max=0xF, min=0, rise=1, fall=1.
